// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory access arbiter.
// Grant selection helper covers both fixed-priority and round-robin (MEM_ARB_RR_EN) builds.
package mem_arb_pkg;

  localparam int unsigned LATENCY_DEF = 7;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // D wins a tie unless round-robin is enabled, then the side not granted last wins.
  function automatic grant_e pick_grant(input logic eff_i, input logic eff_d,
                                        input grant_e last, input logic rr_en);
    grant_e g;
    g = eff_d ? GNT_D : GNT_I;
    if (rr_en && eff_i && eff_d) g = (last == GNT_D) ? GNT_I : GNT_D;
    return g;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing the fixed memory latency; zero_c flags the last BUSY cycle.
module mem_lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (load)  cnt <= load_val;
    else if (dec)   cnt <= cnt - CNT_W'(1);
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates I-cache and D-cache misses onto one fixed-latency memory and drives the pipeline stall.
// Define MEM_ARB_RR_EN to break I/D ties round-robin instead of fixed D-over-I priority.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF,  // legal range 1..15
  parameter int unsigned DATA_W  = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              IReq,
  input  logic [DATA_W-1:0] IAddr,
  input  logic              DReq,
  input  logic              DWrite,
  input  logic [DATA_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              MemReq,
  output logic              MemWrite,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic [DATA_W-1:0] RData,
  output logic              IDone,
  output logic              DDone,
  output logic              WriteAll
);

`ifdef MEM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  state_e state;
  grant_e grant;
  grant_e last_grant;
  grant_e pick;
  logic   served_i;
  logic   served_d;
  logic   eff_i;
  logic   eff_d;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

  // Served flags hide a requester already serviced while the pipeline still stalls for the other.
  assign eff_i    = IReq & ~served_i;
  assign eff_d    = DReq & ~served_d;
  assign pick     = pick_grant(eff_i, eff_d, last_grant, RR_EN);
  assign cnt_load = (state == IDLE) && (eff_i || eff_d);
  assign cnt_dec  = (state == BUSY) && !cnt_zero;

  mem_lat_counter u_cnt (
    .clk      (CLK),
    .rst_n    (RSTn),
    .load     (cnt_load),
    .load_val (CNT_W'(LATENCY - 1)),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero)
  );

  // Pipeline stall: forced high while in reset, otherwise follows outstanding unserved misses.
  always_comb begin
    WriteAll = 1'b1;
    if (RSTn) begin
      case (state)
        IDLE:    WriteAll = ~(eff_i | eff_d);
        BUSY:    WriteAll = 1'b0;
        DONE:    WriteAll = (grant == GNT_D) ? ~eff_i : ~eff_d;
        default: WriteAll = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      grant      <= GNT_I;
      last_grant <= GNT_I;
      served_i   <= 1'b0;
      served_d   <= 1'b0;
      MemReq     <= 1'b0;
      MemWrite   <= 1'b0;
      MemAddr    <= '0;
      MemWData   <= '0;
      RData      <= '0;
      IDone      <= 1'b0;
      DDone      <= 1'b0;
    end else begin
      IDone <= 1'b0;
      DDone <= 1'b0;
      if (WriteAll) begin
        served_i <= 1'b0;
        served_d <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (eff_i || eff_d) begin
            grant    <= pick;
            MemReq   <= 1'b1;
            MemWrite <= (pick == GNT_D) && DWrite;
            MemAddr  <= (pick == GNT_D) ? DAddr : IAddr;
            if (pick == GNT_D) MemWData <= DWData;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_zero) begin
            MemReq     <= 1'b0;
            if (!MemWrite) RData <= MemRData;
            last_grant <= grant;
            if (grant == GNT_D) begin
              DDone    <= 1'b1;
              served_d <= 1'b1;
            end else begin
              IDone    <= 1'b1;
              served_i <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
